fetch_unit: RTL and testbench

Instruction fetch front end. Generates the program counter, issues reads to the synchronous instruction memory, and buffers returned instructions with their PCs in a small queue. Decode drains the queue through a valid/ready handshake. The block also owns the PC register, including reset, sequential increment and redirect from execute. It sits between instruction memory and the IF/ID pipeline register.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit signal bundle: instruction memory read port, execute redirect and
// the valid/ready queue output toward decode.
interface fetch_unit_if #(
  parameter int PC_WIDTH    = 18,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_WIDTH-1:0]    out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues reads to a 1-cycle
// synchronous instruction memory and queues {pc, instr} pairs for decode.
module fetch_unit #(
  parameter int                  PC_WIDTH    = 18,
  parameter int                  INSTR_WIDTH = 32,
  parameter int                  DEPTH       = 4,
  parameter int                  PC_STEP     = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int                  PTR_W = $clog2(DEPTH);
  localparam int                  CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]    FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]      LIMIT = (CNT_W + 1)'(DEPTH);
  localparam logic [PC_WIDTH-1:0] STEP  = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    rsp_pc;
  logic                   rsp_pending;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;
  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   valid;
  logic [CNT_W:0]         inflight;

  // NOTE: every always_comb target gets a value before any condition, so no latch can be inferred.
  always_comb begin
    inflight = {1'b0, count} + {{CNT_W{1'b0}}, rsp_pending};
    valid    = (count != '0);
    // Space check uses registered state only, keeping out_ready off the request path.
    issue    = !reset && !bus.redirect_valid && (inflight < LIMIT);
    push     = rsp_pending && !bus.redirect_valid;
    pop      = valid && bus.out_ready;
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;
  assign bus.out_valid = valid;
  assign bus.out_pc    = pc_mem[rd_ptr];
  assign bus.out_instr = instr_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      rsp_pc      <= '0;
      rsp_pending <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      // NOTE: storage is reset so the head fields read as zero while the queue is empty after reset.
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      rsp_pending <= issue;
      if (issue) begin
        rsp_pc <= pc;
      end

      if (bus.redirect_valid) begin
        // Flush: in-flight response is dropped, queue emptied, PC retargeted.
        pc     <= bus.redirect_pc;
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (issue) begin
          pc <= pc + STEP;
        end
        if (push) begin
          pc_mem[wr_ptr]    <= rsp_pc;
          instr_mem[wr_ptr] <= bus.imem_rdata;
          wr_ptr            <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // The issue rule reserves a slot for every outstanding response.
  always_ff @(posedge clk) begin
    if (!reset && push && !pop) begin
      assert (count != FULL) else $error("fetch_unit: instruction queue overflow");
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM returns A000_0000 + address, delivered
// entries are compared against a scoreboard queue of expected {pc, instr}.
module tb_fetch_unit;
  logic clk;
  logic reset;

  fetch_unit_if #(.PC_WIDTH(18), .INSTR_WIDTH(32)) bus ();
  fetch_unit_if #(.PC_WIDTH(18), .INSTR_WIDTH(32)) bus2 ();

  fetch_unit #(
    .PC_WIDTH(18), .INSTR_WIDTH(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(18'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_unit #(
    .PC_WIDTH(18), .INSTR_WIDTH(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(18'h3FFF8)
  ) dut_top (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct packed {
    logic [17:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t q[$];
  int     checks = 0;
  int     errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs: data one cycle after a request, poison otherwise.
  always @(posedge clk) begin
    bus.imem_rdata  <= bus.imem_req  ? 32'hA000_0000 + 32'(bus.imem_addr)  : 32'hDEAD_BEEF;
    bus2.imem_rdata <= bus2.imem_req ? 32'hA000_0000 + 32'(bus2.imem_addr) : 32'hDEAD_BEEF;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic entry_t mk(input logic [17:0] pc);
    entry_t e;
    e.pc    = pc;
    e.instr = 32'hA000_0000 + 32'(pc);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [17:0] start, input int n);
    logic [17:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      q.push_back(mk(p));
      p = p + 18'd4;
    end
  endtask

  // Starts at the beginning of a cycle; ends at the negedge of the last cycle used.
  task automatic drain(input string tag, input int n, input int budget, output int used);
    int     got;
    entry_t e;
    got  = 0;
    used = 0;
    while (got < n && used < budget) begin
      if (used != 0) next();
      @(negedge clk);
      used++;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL %s: unexpected delivery pc=%0h with empty scoreboard", tag, bus.out_pc);
        end else begin
          e = q.pop_front();
          check(tag, {bus.out_pc, bus.out_instr}, {e.pc, e.instr});
        end
        got++;
      end
    end
    check({tag, "_count"}, got, n);
  endtask

  // Holds reset across three edges, checks reset outputs, returns at the start of cycle 0.
  task automatic do_reset(input logic rdy);
    reset              = 1'b1;
    bus.out_ready      = rdy;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    q.delete();
    next();
    next();
    @(negedge clk);
    check("rst_req",   bus.imem_req,  0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_pc",    bus.out_pc,    0);
    check("rst_instr", bus.out_instr, 0);
    next();
    reset = 1'b0;
  endtask

  initial begin
    int     used;
    entry_t e;

    reset               = 1'b1;
    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus2.out_ready      = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;

    // Streaming from reset with decode always ready.
    do_reset(1'b1);
    push_stream(18'h0, 8);
    @(negedge clk);
    check("t1_c0_req",  bus.imem_req,  1);
    check("t1_c0_addr", bus.imem_addr, 0);
    next();
    @(negedge clk);
    check("t1_c1_valid", bus.out_valid, 0);
    next();
    drain("t1_pop", 8, 8, used);
    check("t1_throughput", used, 8);

    // Decode stalled from reset: queue fills, fetch stops, then resumes.
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t2_req",  bus.imem_req,  1);
      check("t2_addr", bus.imem_addr, 4 * c);
      next();
    end
    for (int c = 4; c < 8; c++) begin
      @(negedge clk);
      check("t2_stall_req", bus.imem_req, 0);
      next();
    end
    check("t2_pc",       bus.imem_addr, 18'h10);
    check("t2_hold_pc",  bus.out_pc,    0);
    check("t2_hold_ins", bus.out_instr, 32'hA000_0000);
    push_stream(18'h0, 10);
    bus.out_ready = 1'b1;
    #1;
    check("t2_no_comb_req", bus.imem_req, 0);
    drain("t2_pop", 10, 25, used);
    next();

    // Redirect to 0x100 in cycle 6 while streaming.
    do_reset(1'b1);
    push_stream(18'h0, 5);
    push_stream(18'h100, 3);
    next();
    next();
    drain("t3_pre", 4, 4, used);
    next();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 18'h100;
    #1;
    check("t3_c6_req", bus.imem_req, 0);
    drain("t3_c6_pop", 1, 1, used);
    next();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_c7_valid", bus.out_valid, 0);
    check("t3_c7_req",   bus.imem_req,  1);
    check("t3_c7_addr",  bus.imem_addr, 18'h100);
    next();
    @(negedge clk);
    check("t3_c8_valid", bus.out_valid, 0);
    next();
    drain("t3_post", 3, 3, used);
    check("t3_latency", used, 3);

    // Full, stalled queue flushed by a redirect to 0x200.
    do_reset(1'b0);
    repeat (6) next();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 18'h200;
    #1;
    check("t4_full_valid", bus.out_valid, 1);
    check("t4_redir_req",  bus.imem_req,  0);
    next();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    @(negedge clk);
    check("t4_flushed", bus.out_valid, 0);
    check("t4_req",     bus.imem_req,  1);
    check("t4_addr",    bus.imem_addr, 18'h200);
    push_stream(18'h200, 3);
    next();
    drain("t4_pop", 3, 6, used);

    // PC wrap at the top of the address space (second instance).
    do_reset(1'b1);
    push_stream(18'h3FFF8, 4);
    next();
    next();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_valid", bus2.out_valid, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("t5_pop", {bus2.out_pc, bus2.out_instr}, {e.pc, e.instr});
      end
      next();
    end

    // One-cycle reset with three entries queued.
    do_reset(1'b0);
    repeat (4) next();
    reset = 1'b1;
    #1;
    check("t6_queued_valid", bus.out_valid, 1);
    check("t6_rst_req",      bus.imem_req,  0);
    next();
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t6_valid", bus.out_valid, 0);
    check("t6_instr", bus.out_instr, 0);
    check("t6_req",   bus.imem_req,  1);
    check("t6_addr",  bus.imem_addr, 0);
    push_stream(18'h0, 4);
    next();
    @(negedge clk);
    check("t6_c1_valid", bus.out_valid, 0);
    next();
    drain("t6_pop", 4, 4, used);
    check("t6_latency", used, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
